ex_mdu: RTL
===========

# ex_mdu

Parametrised multi-cycle multiply/divide unit beside the EX-stage ALU, owning the HI/LO register pair for the SPECIAL multiply/divide/move group. MULT/MULTU/DIV/DIVU run iteratively, one bit per cycle, without blocking the pipeline. Only a later MDU instruction that issues while the unit is busy raises `stall`. Sits in EX in parallel with the ALU, taking the same `func`, `data_a`, `data_b` and `ex_stop` inputs.

## Interface
- `WIDTH`, 32: operand, HI and LO width.
- `CNT_W`, 6: iteration-counter width; must satisfy 2^CNT_W > WIDTH.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: EX holds a SPECIAL instruction (op = 000000).
- `func` in 6: SPECIAL function field.
- `ex_stop` in 1: EX holds a bubble; `start` is ignored.
- `flush` in 1: kill the in-flight operation.
- `data_a` in WIDTH: rs operand.
- `data_b` in WIDTH: rt operand.
- `result` out WIDTH: MFHI/MFLO read data, combinational from HI/LO.
- `hi_o` out WIDTH: HI register value.
- `lo_o` out WIDTH: LO register value.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `stall` out 1: combinational; freeze IF/ID/EX this cycle.

## Operation
- A valid issue is `start & ~ex_stop` with a recognised func:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - Any other func is ignored.
- States:
  - IDLE: accepts an issue.
  - MUL: shift-add iteration.
  - DIV: restoring-division iteration.
  - DONE: sign fix-up and HI/LO write.
- IDLE, MULT/MULTU issue:
  - Latch |a| and |b| (signed) or raw operands (unsigned); record result sign.
  - Counter = WIDTH; go to MUL.
- IDLE, DIV/DIVU issue:
  - Latch operands the same way; counter = WIDTH; go to DIV.
  - If `data_b` = 0: go directly to DONE with HI = `data_a` and LO = all ones.
- MUL/DIV: one iteration per cycle, counter decrements; go to DONE when the counter reaches 0.
- DONE:
  - Negate the product if the signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - HI/LO written at the edge ending DONE; the unit returns to IDLE on that same edge.
- Results:
  - MULT/MULTU: product to {HI, LO} (2·WIDTH bits).
  - DIV/DIVU: quotient to LO, remainder to HI.
- MTHI/MTLO in IDLE: write `data_a` into HI/LO at the next edge.
- MFHI/MFLO in IDLE: `result` = HI/LO in the same cycle.
- `stall` = valid issue of any recognised func while `busy`. The stalled instruction is re-presented and accepted once the unit is back in IDLE.
- `flush`:
  - Next edge returns the unit to IDLE.
  - HI/LO unchanged, no `done` pulse.
  - Takes priority over a simultaneous issue or DONE write.
- Reset: state IDLE, HI = LO = 0, counter 0, `busy` = `done` = `stall` = 0, `result` = 0.

## Timing
- Issue sampled at edge E0.
- Non-zero divide and multiply:
  - `busy` high from E0 through E(WIDTH+1).
  - `done` high between E(WIDTH) and E(WIDTH+1).
  - New HI/LO visible after E(WIDTH+1).
- Divide by zero: `busy` and `done` high for the single cycle after E0; HI/LO visible after E1.
- MT*/MF* in IDLE: zero added latency, `busy` stays 0.
- A stalled MF* is accepted in the first IDLE cycle and reads the freshly written HI/LO.
- `rst_n` assertion mid-operation clears the state immediately (asynchronous); no partial write reaches HI/LO.

## Configuration
- `EX_MDU_DIV_EN` defined: DIV/DIVU implemented as specified.
- `EX_MDU_DIV_EN` undefined:
  - Divider datapath and DIV state are compiled out.
  - DIV/DIVU are not recognised funcs: no state change, no stall, HI/LO unchanged.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002 -> `done` in cycle 32 after issue; HI = 0x00000001, LO = 0xFFFFFFFE.
- MULT 0xFFFFFFFD × 0x00000005 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- Divide cases:
  - DIV 0xFFFFFFF9 / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7 / 0 -> `busy` for 1 cycle, HI = 0x00000007, LO = 0xFFFFFFFF.
- MULTU 3 × 4, then MFLO issued 5 cycles later -> `stall` high until the unit is back in IDLE; MFLO then returns `result` = 0x0000000C.
- MTHI 0x1234, then MULTU issued with `flush` asserted in the 10th busy cycle -> `busy` low next cycle; HI = 0x1234 and LO unchanged; no `done` pulse.
- `rst_n` pulsed low mid-DIV -> state IDLE and HI = LO = 0 immediately. Build without `EX_MDU_DIV_EN`: DIV leaves `busy` = 0.

Source files
------------

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit owning HI/LO, one bit per cycle beside the EX ALU.
// Define EX_MDU_DIV_EN to build the restoring divider; without it DIV/DIVU are ignored.
module ex_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic             ex_stop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef EX_MDU_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef EX_MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, opd_q, hi_q, lo_q;
  logic             neg_q_q;
`ifdef EX_MDU_DIV_EN
  logic             neg_r_q, op_div_q;
  logic [WIDTH:0]   div_shift, div_diff;
`endif

  // Handshake: an issue (start & ~ex_stop, recognised func) is accepted on the
  // edge where stall is low; while stall is high EX holds and re-presents it.
  logic issue, is_mul, is_div, is_mt, is_mf, recog, is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b, fin_hi, fin_lo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign issue  = start & ~ex_stop;
  assign is_mul = issue & (func == F_MULT || func == F_MULTU);
`ifdef EX_MDU_DIV_EN
  assign is_div = issue & (func == F_DIV || func == F_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign is_mt  = issue & (func == F_MTHI || func == F_MTLO);
  assign is_mf  = issue & (func == F_MFHI || func == F_MFLO);
  assign recog  = is_mul | is_div | is_mt | is_mf;

  // func[0] clear selects the signed variant of both MULT and DIV.
  assign is_signed = ~func[0];
  assign a_neg     = is_signed & data_a[WIDTH-1];
  assign b_neg     = is_signed & data_b[WIDTH-1];
  assign abs_a     = a_neg ? -data_a : data_a;
  assign abs_b     = b_neg ? -data_b : data_b;

  // Shift-add: acc holds the running upper half, q the multiplier/low half.
  assign mul_sum = {1'b0, acc_q} + ({1'b0, opd_q} & {(WIDTH+1){q_q[0]}});
`ifdef EX_MDU_DIV_EN
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
`endif

  assign prod     = {acc_q, q_q};
  assign prod_fix = neg_q_q ? -prod : prod;

  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
`ifdef EX_MDU_DIV_EN
    if (op_div_q) begin
      fin_lo = neg_q_q ? -q_q : q_q;
      fin_hi = neg_r_q ? -acc_q : acc_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul) state_d = S_MUL;
`ifdef EX_MDU_DIV_EN
          else if (is_div) state_d = (data_b == '0) ? S_DONE : S_DIV;
`endif
        end
        S_MUL:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
`ifdef EX_MDU_DIV_EN
        S_DIV:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
`endif
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE) & ~flush;
    stall  = recog & busy;
    result = (is_mf & ~busy) ? (func[1] ? lo_q : hi_q) : '0;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      opd_q   <= '0;
      neg_q_q <= 1'b0;
`ifdef EX_MDU_DIV_EN
      neg_r_q  <= 1'b0;
      op_div_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mul) begin
            cnt_q   <= CNT_W'(WIDTH);
            acc_q   <= '0;
            q_q     <= abs_b;
            opd_q   <= abs_a;
            neg_q_q <= a_neg ^ b_neg;
`ifdef EX_MDU_DIV_EN
            op_div_q <= 1'b0;
`endif
          end
`ifdef EX_MDU_DIV_EN
          else if (is_div) begin
            op_div_q <= 1'b1;
            if (data_b == '0) begin
              // Divide by zero skips iteration: HI = dividend, LO = all ones.
              cnt_q   <= '0;
              acc_q   <= data_a;
              q_q     <= '1;
              opd_q   <= '0;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end else begin
              cnt_q   <= CNT_W'(WIDTH);
              acc_q   <= '0;
              q_q     <= abs_a;
              opd_q   <= abs_b;
              neg_q_q <= a_neg ^ b_neg;
              neg_r_q <= a_neg;
            end
          end
`endif
        end
        S_MUL: begin
          cnt_q <= cnt_q - CNT_W'(1);
          acc_q <= mul_sum[WIDTH:1];
          q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
        end
`ifdef EX_MDU_DIV_EN
        S_DIV: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (!div_diff[WIDTH]) begin
            acc_q <= div_diff[WIDTH-1:0];
            q_q   <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= div_shift[WIDTH-1:0];
            q_q   <= {q_q[WIDTH-2:0], 1'b0};
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // HI/LO only change via MT* in IDLE or the DONE write; flush blocks both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush) begin
      if (state_q == S_IDLE && is_mt) begin
        if (func[1]) lo_q <= data_a;
        else         hi_q <= data_a;
      end else if (state_q == S_DONE) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end
endmodule
